stopwatch_lap: RTL and testbench

STOPWATCH_LAP -- requirements
Module: stopwatch_lap

---
 rtl/stopwatch_lap.sv | 170 +++++++++++++++++
 tb/tb_stopwatch_lap.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap.sv
// MM:SS stopwatch with four 7-segment digit outputs and a lap-time buffer.
// Time advances one second every TICK_CYCLES clocks while running; laps read back as BCD.
module stopwatch_lap #(
  parameter int TICK_CYCLES    = 50000000,
  parameter int LAP_DEPTH      = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         clear,
  input  logic                         lap_store,
  input  logic                         rd_en,
  input  logic [$clog2(LAP_DEPTH)-1:0] rd_addr,
  output logic [15:0]                  rd_data,
  output logic                         rd_valid,
  output logic [6:0]                   sec1,
  output logic [6:0]                   sec2,
  output logic [6:0]                   min1,
  output logic [6:0]                   min2,
  output logic                         tick,
  output logic                         wrap,
  output logic                         running,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_full,
  output logic                         lap_ovf
);

  localparam int              AW         = $clog2(LAP_DEPTH);
  localparam int              PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [AW:0]     LAP_MAX    = (AW+1)'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    d_sec1, d_sec2, d_min1, d_min2;
  logic [15:0]   time_bcd;
  logic [15:0]   lap_mem [LAP_DEPTH];
  logic          lap_req;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (pause) state_nxt = PAUSE;
        PAUSE:   if (start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    tick    = 1'b0;
    wrap    = 1'b0;
    if (state == RUN) begin
      running = 1'b1;
      tick    = (presc == PRESC_LAST);
      wrap    = tick && d_sec1 == 4'd9 && d_sec2 == 4'd5 && d_min1 == 4'd9 && d_min2 == 4'd5;
    end
  end

  // Prescaler and BCD time; IDLE always holds 00:00 with the prescaler at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      d_sec1 <= '0;
      d_sec2 <= '0;
      d_min1 <= '0;
      d_min2 <= '0;
    end else if (clear || state == IDLE) begin
      presc  <= '0;
      d_sec1 <= '0;
      d_sec2 <= '0;
      d_min1 <= '0;
      d_min2 <= '0;
    end else if (state == RUN) begin
      if (tick) begin
        presc <= '0;
        if (d_sec1 != 4'd9) begin
          d_sec1 <= d_sec1 + 4'd1;
        end else begin
          d_sec1 <= '0;
          if (d_sec2 != 4'd5) begin
            d_sec2 <= d_sec2 + 4'd1;
          end else begin
            d_sec2 <= '0;
            if (d_min1 != 4'd9) begin
              d_min1 <= d_min1 + 4'd1;
            end else begin
              d_min1 <= '0;
              d_min2 <= (d_min2 == 4'd5) ? 4'd0 : d_min2 + 4'd1;
            end
          end
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign time_bcd = {d_min2, d_min1, d_sec2, d_sec1};
  assign lap_req  = lap_store && !clear && state != IDLE;
  assign lap_full = (lap_count == LAP_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else if (clear) begin
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else if (lap_req) begin
      if (lap_full) lap_ovf   <= 1'b1;
      else          lap_count <= lap_count + 1'b1;
    end
  end

  // NOTE: the buffer has no reset; reads beyond lap_count are masked to zero instead.
  always_ff @(posedge clk) begin
    if (lap_req && !lap_full) lap_mem[lap_count[AW-1:0]] <= time_bcd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_addr} < lap_count) ? lap_mem[rd_addr] : 16'h0000;
    end
  end

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  assign sec1 = seg_encode(d_sec1);
  assign sec2 = seg_encode(d_sec2);
  assign min1 = seg_encode(d_min1);
  assign min2 = seg_encode(d_min2);

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: a seconds-level model compared every cycle,
// directed scenarios with literal expectations, then randomized command traffic.
module tb_stopwatch_lap;

  localparam int TC = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  localparam logic [6:0] SEG_HI [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                         7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                         7'b1111111, 7'b1111011};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, pause = 1'b0, clear = 1'b0, lap_store = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic [6:0]    sec1, sec2, min1, min2;
  logic          tick, wrap, running;
  logic [AW:0]   lap_count;
  logic          lap_full, lap_ovf;

  int checks   = 0;
  int failures = 0;

  stopwatch_lap #(.TICK_CYCLES(TC), .LAP_DEPTH(D), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .lap_store(lap_store), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .tick(tick), .wrap(wrap), .running(running), .lap_count(lap_count),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole seconds elapsed, cycles spent in the current second, lap list.
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_secs = 0, m_phase = 0, m_laps_n = 0;
  int          m_laps [D];
  bit          m_ovf = 1'b0, m_rd_valid = 1'b0;
  logic [15:0] m_rd_data = '0;

  function automatic logic [15:0] bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    return (d < 4'd10) ? ~SEG_HI[d] : ~7'b0000001;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit tk;
    if (!rst) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_laps_n = 0;
      m_ovf = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    end else begin
      tk = (m_mode == M_RUN) && (m_phase == TC - 1);
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = (int'(rd_addr) < m_laps_n) ? bcd(m_laps[rd_addr]) : 16'h0000;
      if (clear) begin
        m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_laps_n = 0; m_ovf = 1'b0;
      end else begin
        if (lap_store && m_mode != M_IDLE) begin
          if (m_laps_n < D) begin
            m_laps[m_laps_n] = m_secs;
            m_laps_n++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (m_mode == M_RUN) begin
          if (tk) begin
            m_phase = 0;
            m_secs  = (m_secs + 1) % 3600;
          end else begin
            m_phase++;
          end
        end
        if (m_mode == M_RUN && pause)      m_mode = M_PAUSE;
        else if (m_mode != M_RUN && start) m_mode = M_RUN;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] t;
    bit          tk_e;
    t    = bcd(m_secs);
    tk_e = (m_mode == M_RUN) && (m_phase == TC - 1);
    check("sec1",      32'(sec1),      32'(seg(t[3:0])));
    check("sec2",      32'(sec2),      32'(seg(t[7:4])));
    check("min1",      32'(min1),      32'(seg(t[11:8])));
    check("min2",      32'(min2),      32'(seg(t[15:12])));
    check("tick",      32'(tick),      32'(tk_e));
    check("wrap",      32'(wrap),      32'(tk_e && m_secs == 3599));
    check("running",   32'(running),   32'(m_mode == M_RUN));
    check("lap_count", 32'(lap_count), 32'(m_laps_n));
    check("lap_full",  32'(lap_full),  32'(m_laps_n == D));
    check("lap_ovf",   32'(lap_ovf),   32'(m_ovf));
    check("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
    check("rd_data",   32'(rd_data),   32'(m_rd_data));
  end

  task automatic cmd(input bit s, input bit p, input bit c, input bit l);
    start = s; pause = p; clear = c; lap_store = l;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; clear = 1'b0; lap_store = 1'b0;
  endtask

  task automatic read(input int addr);
    rd_en = 1'b1; rd_addr = AW'(addr);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, pos;
    repeat (2) @(negedge clk);
    check("rst_sec1", 32'(sec1), 32'(7'b0000001));
    check("rst_min2", 32'(min2), 32'(7'b0000001));
    check("rst_running", 32'(running), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 40 cycles of running yields ten seconds.
    cmd(1, 0, 0, 0);
    n = 0;
    repeat (40) begin
      if (tick) n++;
      @(negedge clk);
    end
    check("ticks_in_40", 32'(n), 32'd10);
    check("t10_sec1", 32'(sec1), 32'(7'b0000001));
    check("t10_sec2", 32'(sec2), 32'(7'b1001111));
    check("t10_min1", 32'(min1), 32'(7'b0000001));
    cmd(0, 0, 1, 0);

    // Pause at 00:03 with two cycles of the second already elapsed.
    cmd(1, 0, 0, 0);
    repeat (13) @(negedge clk);
    check("pause_at_3_sec1", 32'(sec1), 32'(7'b0000110));
    cmd(0, 1, 0, 0);
    check("paused_running", 32'(running), 32'd0);
    check("paused_phase_model", 32'(m_phase), 32'd2);
    n = 0;
    repeat (20) begin
      if (tick) n++;
      @(negedge clk);
    end
    check("ticks_while_paused", 32'(n), 32'd0);
    n = 0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!tick && n < 20);
    check("resume_to_tick", 32'(n), 32'd2);
    cmd(0, 0, 1, 0);

    // Run all the way to 59:59 and through the wrap.
    cmd(1, 0, 0, 0);
    n = 0;
    while (!wrap && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check("cycles_to_wrap", 32'(n), 32'd14399);
    check("wrap_with_tick", 32'(tick), 32'd1);
    @(negedge clk);
    check("after_wrap_sec2", 32'(sec2), 32'(7'b0000001));
    check("after_wrap_min2", 32'(min2), 32'(7'b0000001));
    cmd(0, 0, 1, 0);

    // Five laps at 00:01..00:05 into a four-entry buffer.
    cmd(1, 0, 0, 0);
    pos = 0;
    for (int t = 1; t <= 5; t++) begin
      repeat (4 * t + 1 - pos) @(negedge clk);
      cmd(0, 0, 0, 1);
      pos = 4 * t + 2;
    end
    check("laps_count", 32'(lap_count), 32'd4);
    check("laps_full", 32'(lap_full), 32'd1);
    check("laps_ovf", 32'(lap_ovf), 32'd1);
    read(2);
    check("rd2_valid", 32'(rd_valid), 32'd1);
    check("rd2_data", 32'(rd_data), 32'h0003);
    @(negedge clk);
    check("rd2_valid_drop", 32'(rd_valid), 32'd0);
    check("rd2_data_hold", 32'(rd_data), 32'h0003);

    // Clear beats coincident pause and lap_store.
    cmd(0, 1, 1, 1);
    check("clr_running", 32'(running), 32'd0);
    check("clr_sec1", 32'(sec1), 32'(7'b0000001));
    check("clr_lap_count", 32'(lap_count), 32'd0);
    check("clr_lap_ovf", 32'(lap_ovf), 32'd0);
    read(0);
    check("clr_rd0_data", 32'(rd_data), 32'h0000);

    // Randomized command traffic.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      pause     = ($urandom_range(0, 29) == 0);
      if (start && pause && m_mode != M_RUN) pause = 1'b0;
      clear     = ($urandom_range(0, 299) == 0);
      lap_store = ($urandom_range(0, 9) == 0);
      rd_en     = ($urandom_range(0, 2) == 0);
      rd_addr   = AW'($urandom);
      @(negedge clk);
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0; lap_store = 1'b0; rd_en = 1'b0;

    // Asynchronous reset in the middle of a run at 00:07.
    cmd(0, 0, 1, 0);
    cmd(1, 0, 0, 0);
    repeat (5) @(negedge clk);
    cmd(0, 0, 0, 1);
    read(0);
    repeat (21) @(negedge clk);
    check("pre_rst_sec1", 32'(sec1), 32'(7'b0001111));
    check("pre_rst_rd_data", 32'(rd_data), 32'h0001);
    #2 rst = 1'b0;
    #1;
    check("arst_sec1", 32'(sec1), 32'(7'b0000001));
    check("arst_running", 32'(running), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    check("arst_lap_count", 32'(lap_count), 32'd0);
    check("arst_lap_full", 32'(lap_full), 32'd0);
    check("arst_lap_ovf", 32'(lap_ovf), 32'd0);
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'h0000);
    @(negedge clk);
    rst = 1'b1;
    cmd(1, 0, 0, 0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
